// File: rtl/key_pkg.sv
// Shared definitions for the multi-key front end: FSM state encoding,
// default count constants and counter-width helpers.
package key_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPressDb,
    StHeld,
    StLongHeld,
    StRelDb
  } key_state_e;

  localparam int unsigned KeyNumDefault   = 4;
  localparam int unsigned McntDbDefault   = 1_000_000;
  localparam int unsigned McntLongDefault = 100_000_000;
  localparam int unsigned McntRptDefault  = 10_000_000;

  // Bits needed to hold counts 0 .. max_cnt-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    return (max_cnt <= 1) ? 1 : $clog2(max_cnt);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_fsm_single.sv
// One key: 2-flop synchroniser, press/long/repeat/release FSM and counters.
// Auto-repeat is built only when KEY_AUTO_REPEAT_EN is defined.
module key_fsm_single
  import key_pkg::*;
#(
  parameter int unsigned MCNT_DB   = McntDbDefault,
  parameter int unsigned MCNT_LONG = McntLongDefault,
  parameter int unsigned MCNT_RPT  = McntRptDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic state_o,
  output logic short_o,
  output logic long_o,
  output logic rpt_o
);

  localparam int unsigned CntW = cnt_width(max3(MCNT_DB, MCNT_LONG, MCNT_RPT));
  localparam int unsigned DbW  = cnt_width(MCNT_DB);

  localparam logic [CntW-1:0] DbLast   = CntW'(MCNT_DB - 1);
  localparam logic [CntW-1:0] LongLast = CntW'(MCNT_LONG - 1);
  localparam logic [DbW-1:0]  RelLast  = DbW'(MCNT_DB - 1);
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CntW-1:0] RptLast  = CntW'(MCNT_RPT - 1);
`endif

  logic [1:0]      sync_q;
  logic            key_up;
  key_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [DbW-1:0]  rel_q;
  logic            origin_long_q;
  logic            level_q;
  logic            short_q;
  logic            long_q;

  // Synchroniser, reset to the released level so a held key is seen as a new press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_ni};
    end
  end

  assign key_up = sync_q[1];

`ifdef KEY_AUTO_REPEAT_EN
  logic rpt_q;
`endif

  // Key FSM with hold/release counters and registered strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rel_q         <= '0;
      origin_long_q <= 1'b0;
      level_q       <= 1'b0;
      short_q       <= 1'b0;
      long_q        <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      rpt_q         <= 1'b0;
`endif
    end else begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      rpt_q   <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (!key_up) begin
            state_q <= StPressDb;
            cnt_q   <= '0;
          end
        end
        StPressDb: begin
          if (key_up) begin
            state_q <= StIdle;
          end else if (cnt_q == DbLast) begin
            state_q <= StHeld;
            level_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StHeld: begin
          if (key_up) begin
            // Hold timer keeps running so a brief release glitch does not shift Key_long.
            state_q       <= StRelDb;
            origin_long_q <= 1'b0;
            rel_q         <= '0;
            if (cnt_q != LongLast) cnt_q <= cnt_q + CntW'(1);
          end else if (cnt_q == LongLast) begin
            state_q <= StLongHeld;
            long_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StLongHeld: begin
          if (key_up) begin
            state_q       <= StRelDb;
            origin_long_q <= 1'b1;
            rel_q         <= '0;
          end
`ifdef KEY_AUTO_REPEAT_EN
          else if (cnt_q == RptLast) begin
            rpt_q <= 1'b1;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
`endif
        end
        StRelDb: begin
          // Hold timer saturates at the long threshold; the HELD state fires the pulse.
          if (!origin_long_q && (cnt_q != LongLast)) cnt_q <= cnt_q + CntW'(1);
          if (!key_up) begin
            state_q <= origin_long_q ? StLongHeld : StHeld;
          end else if (rel_q == RelLast) begin
            state_q <= StIdle;
            level_q <= 1'b0;
            short_q <= !origin_long_q;
            cnt_q   <= '0;
          end else begin
            rel_q <= rel_q + DbW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign state_o = level_q;
  assign short_o = short_q;
  assign long_o  = long_q;
`ifdef KEY_AUTO_REPEAT_EN
  assign rpt_o   = rpt_q;
`else
  assign rpt_o   = 1'b0;
`endif

endmodule

// File: rtl/key_event_ctrl.sv
// Multi-key front end: KEY_NUM independent debounced keys with short, long and
// (when KEY_AUTO_REPEAT_EN is defined) auto-repeat strobes.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int unsigned KEY_NUM   = KeyNumDefault,
  parameter int unsigned MCNT_DB   = McntDbDefault,
  parameter int unsigned MCNT_LONG = McntLongDefault,
  parameter int unsigned MCNT_RPT  = McntRptDefault
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [KEY_NUM-1:0] Key,
  output logic [KEY_NUM-1:0] Key_state,
  output logic [KEY_NUM-1:0] Key_short,
  output logic [KEY_NUM-1:0] Key_long,
  output logic [KEY_NUM-1:0] Key_rpt
);

  // One fully independent key channel per input bit.
  for (genvar i = 0; i < int'(KEY_NUM); i++) begin : g_key
    key_fsm_single #(
      .MCNT_DB  (MCNT_DB),
      .MCNT_LONG(MCNT_LONG),
      .MCNT_RPT (MCNT_RPT)
    ) u_key (
      .clk_i  (Clk),
      .rst_ni (Reset_n),
      .key_ni (Key[i]),
      .state_o(Key_state[i]),
      .short_o(Key_short[i]),
      .long_o (Key_long[i]),
      .rpt_o  (Key_rpt[i])
    );
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl (MCNT_DB=10, MCNT_LONG=100, MCNT_RPT=20).
// Edge numbers count posedges after the raw inputs were last set up.
module tb_key_event_ctrl;

  localparam int unsigned N = 4;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int RptN = 4;
  localparam int RptFirst = 133;
`else
  localparam int RptN = 0;
  localparam int RptFirst = -1;
`endif

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic [N-1:0] Key;
  logic [N-1:0] Key_state, Key_short, Key_long, Key_rpt;

  key_event_ctrl #(
    .KEY_NUM  (N),
    .MCNT_DB  (10),
    .MCNT_LONG(100),
    .MCNT_RPT (20)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Key      (Key),
    .Key_state(Key_state),
    .Key_short(Key_short),
    .Key_long (Key_long),
    .Key_rpt  (Key_rpt)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int edge_no;
  int rise_at[N], fall_at[N], short_at[N], long_at[N], rpt_first[N];
  int short_n[N], long_n[N], rpt_n[N];
  logic [N-1:0] prev_state;

  typedef struct {
    logic [N-1:0] mask;
    int lo_len;
    int rise;
    int fall;
    int short_at;
    int long_at;
    int rpt_n;
    int rpt_first;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic clear_obs();
    edge_no = 0;
    prev_state = Key_state;
    for (int k = 0; k < N; k++) begin
      rise_at[k] = -1; fall_at[k] = -1; short_at[k] = -1; long_at[k] = -1;
      rpt_first[k] = -1; short_n[k] = 0; long_n[k] = 0; rpt_n[k] = 0;
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    edge_no++;
    for (int k = 0; k < N; k++) begin
      if (Key_state[k] && !prev_state[k] && rise_at[k] < 0) rise_at[k] = edge_no;
      if (!Key_state[k] && prev_state[k] && fall_at[k] < 0) fall_at[k] = edge_no;
      if (Key_short[k]) begin
        short_n[k]++;
        if (short_at[k] < 0) short_at[k] = edge_no;
      end
      if (Key_long[k]) begin
        long_n[k]++;
        if (long_at[k] < 0) long_at[k] = edge_no;
      end
      if (Key_rpt[k]) begin
        rpt_n[k]++;
        if (rpt_first[k] < 0) rpt_first[k] = edge_no;
      end
    end
    prev_state = Key_state;
  endtask

  task automatic chk_key(input string tag, input int k, input int rise, input int fall,
                         input int s_at, input int l_at, input int r_n, input int r_first);
    chk($sformatf("%s k%0d rise", tag, k), rise_at[k], rise);
    chk($sformatf("%s k%0d fall", tag, k), fall_at[k], fall);
    chk($sformatf("%s k%0d short_n", tag, k), short_n[k], (s_at >= 0) ? 1 : 0);
    chk($sformatf("%s k%0d short_at", tag, k), short_at[k], s_at);
    chk($sformatf("%s k%0d long_n", tag, k), long_n[k], (l_at >= 0) ? 1 : 0);
    chk($sformatf("%s k%0d long_at", tag, k), long_at[k], l_at);
    chk($sformatf("%s k%0d rpt_n", tag, k), rpt_n[k], r_n);
    chk($sformatf("%s k%0d rpt_first", tag, k), rpt_first[k], r_first);
  endtask

  initial begin
    vecs[0] = '{mask: 4'b0001, lo_len: 50,  rise: 13, fall: 63,  short_at: 63, long_at: -1,
                rpt_n: 0, rpt_first: -1};
    vecs[1] = '{mask: 4'b0010, lo_len: 200, rise: 13, fall: 213, short_at: -1, long_at: 113,
                rpt_n: RptN, rpt_first: RptFirst};
    vecs[2] = '{mask: 4'b1000, lo_len: 5,   rise: -1, fall: -1,  short_at: -1, long_at: -1,
                rpt_n: 0, rpt_first: -1};
    vecs[3] = '{mask: 4'b0100, lo_len: 10,  rise: -1, fall: -1,  short_at: -1, long_at: -1,
                rpt_n: 0, rpt_first: -1};
    vecs[4] = '{mask: 4'b0100, lo_len: 11,  rise: 13, fall: 24,  short_at: 24, long_at: -1,
                rpt_n: 0, rpt_first: -1};
    vecs[5] = '{mask: 4'b1001, lo_len: 50,  rise: 13, fall: 63,  short_at: 63, long_at: -1,
                rpt_n: 0, rpt_first: -1};

    // Reset state
    Reset_n = 1'b0;
    Key = '1;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset state", int'(Key_state), 0);
    chk("reset short", int'(Key_short), 0);
    chk("reset long", int'(Key_long), 0);
    chk("reset rpt", int'(Key_rpt), 0);
    Reset_n = 1'b1;
    repeat (5) step();

    // Table-driven single/simultaneous presses
    for (int v = 0; v < 6; v++) begin
      clear_obs();
      Key = ~vecs[v].mask;
      for (int e = 1; e <= 260; e++) begin
        step();
        if (e == vecs[v].lo_len) Key = '1;
      end
      for (int k = 0; k < N; k++) begin
        if (vecs[v].mask[k])
          chk_key($sformatf("vec%0d", v), k, vecs[v].rise, vecs[v].fall, vecs[v].short_at,
                  vecs[v].long_at, vecs[v].rpt_n, vecs[v].rpt_first);
        else
          chk_key($sformatf("vec%0d", v), k, -1, -1, -1, -1, 0, -1);
      end
    end

    // Bounce on key 2: toggles every 4 cycles for 40 cycles, then settles high
    clear_obs();
    Key = 4'b1011;
    for (int e = 1; e <= 100; e++) begin
      step();
      if (e < 40 && (e % 4) == 0) Key[2] = ~Key[2];
      if (e == 40) Key = '1;
    end
    for (int k = 0; k < N; k++) chk_key("bounce", k, -1, -1, -1, -1, 0, -1);

    // Release glitch of 5 cycles during HELD at count 60
    clear_obs();
    Key = 4'b1110;
    for (int e = 1; e <= 160; e++) begin
      step();
      if (e == 73) Key[0] = 1'b1;
      if (e == 78) Key[0] = 1'b0;
      if (e == 130) Key[0] = 1'b1;
    end
    chk_key("glitch", 0, 13, 143, -1, 113, 0, -1);

    // Reset while key 1 is in LONG_HELD
    clear_obs();
    Key = 4'b1101;
    for (int e = 1; e <= 120; e++) step();
    chk("pre-reset long_at", long_at[1], 113);
    chk("pre-reset state", int'(Key_state[1]), 1);
    clear_obs();
    Reset_n = 1'b0;
    #1;
    chk("async reset state", int'(Key_state), 0);
    chk("async reset pulses", int'(Key_short | Key_long | Key_rpt), 0);
    for (int e = 1; e <= 3; e++) begin
      step();
      chk($sformatf("in reset state e%0d", e), int'(Key_state), 0);
    end
    Reset_n = 1'b1;
    clear_obs();
    for (int e = 1; e <= 120; e++) step();
    chk_key("post-reset", 1, 13, -1, -1, 113, 0, -1);
    Key = '1;
    for (int e = 1; e <= 40; e++) step();
    chk("post-reset release state", int'(Key_state), 0);
    chk("post-reset no short", short_n[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
